// File: rtl/fifo_serializer_pkg.sv
//------------------------------------------------------------------------------
// Module   : fifo_serializer_pkg
// Brief    : Shared types and defaults for the fifo_serializer block: frame
//            sequencer state encoding, default word width and bit period, and
//            the idle level of the serial line.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_serializer_pkg;

   // Default word width (also data bits per serial frame)
   localparam int DATA_W_DEFAULT    = 4;
   // Default clock cycles per serial bit (legal range 1..255)
   localparam int BIT_TICKS_DEFAULT = 4;
   // Level driven on the serial line whenever no frame is in flight
   localparam logic SER_IDLE_LEVEL  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_POP    = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } state_e;

   // True for the states that time a bit on the serial line
   function automatic logic in_frame(input state_e s);
      return (s == ST_START) || (s == ST_DATA) || (s == ST_PARITY) || (s == ST_STOP);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_serializer_tick_counter.sv
//------------------------------------------------------------------------------
// Module   : ser_tick_counter
// Brief    : Bit-period timer. Counts 0..BIT_TICKS-1 while enabled and flags
//            the last cycle of each bit period; held at zero when disabled so
//            every frame starts on a fresh bit boundary.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ser_tick_counter #(
   parameter int BIT_TICKS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   output logic tick_o
);

   // One bit of width is kept even for BIT_TICKS=1 so the counter stays legal
   localparam int               CNT_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_TICKS - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear when idle, wrap on the bit boundary, else advance
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST_CNT) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/fifo_serializer.sv
//------------------------------------------------------------------------------
// Module   : fifo_serializer
// Brief    : Pops words from an upstream FIFO and sends each one as an
//            async-style serial frame: start(0), DATA_W bits LSB first,
//            optional even parity, stop(1). Each bit lasts BIT_TICKS cycles.
//            Build option: define SER_PARITY_EN to insert the even-parity bit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_serializer
   import fifo_serializer_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEFAULT,
   parameter int BIT_TICKS = BIT_TICKS_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_pop,
   output logic              ser_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int                   BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);

   state_e                 state_q;
   logic [DATA_W-1:0]      shift_q;
   logic [BIT_CNT_W-1:0]   bit_cnt_q;
   logic                   ser_out_q;
   logic                   fifo_pop_q;
   logic                   busy_q;
   logic                   frame_done_q;
`ifdef SER_PARITY_EN
   logic                   parity_q;
`endif

   logic                   w_tick;
   logic                   w_in_frame;
   logic [DATA_W-1:0]      w_shift_next;

   assign w_in_frame   = in_frame(state_q);
   assign w_shift_next = shift_q >> 1;

   ser_tick_counter #(
      .BIT_TICKS (BIT_TICKS)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .en_i   (w_in_frame),
      .tick_o (w_tick)
   );

   // Frame sequencer: state, shift register, bit counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         ser_out_q    <= SER_IDLE_LEVEL;
         fifo_pop_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef SER_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         frame_done_q <= 1'b0;
         fifo_pop_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               ser_out_q <= SER_IDLE_LEVEL;
               if (!fifo_empty) begin
                  state_q    <= ST_POP;
                  fifo_pop_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            // The pop edge ends this cycle; the word is on fifo_data in LOAD
            ST_POP: begin
               state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               shift_q   <= fifo_data;
`ifdef SER_PARITY_EN
               parity_q  <= ^fifo_data;
`endif
               ser_out_q <= 1'b0;
               state_q   <= ST_START;
            end
            ST_START: begin
               if (w_tick) begin
                  ser_out_q <= shift_q[0];
                  bit_cnt_q <= '0;
                  state_q   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (bit_cnt_q == LAST_BIT) begin
`ifdef SER_PARITY_EN
                     ser_out_q <= parity_q;
                     state_q   <= ST_PARITY;
`else
                     ser_out_q <= SER_IDLE_LEVEL;
                     state_q   <= ST_STOP;
`endif
                  end else begin
                     shift_q   <= w_shift_next;
                     ser_out_q <= w_shift_next[0];
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  ser_out_q <= SER_IDLE_LEVEL;
                  state_q   <= ST_STOP;
               end
            end
`endif
            // Leaving STOP lands in IDLE, so a waiting word is popped next cycle
            ST_STOP: begin
               if (w_tick) begin
                  ser_out_q    <= SER_IDLE_LEVEL;
                  frame_done_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               ser_out_q <= SER_IDLE_LEVEL;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign fifo_pop   = fifo_pop_q;
   assign ser_out    = ser_out_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo_serializer
// Brief    : Bench for fifo_serializer: a queue-based upstream FIFO feeds the
//            main instance, a frame-level model predicts every output cycle,
//            and literal frames pin the model. A second instance runs with
//            BIT_TICKS=1. Honours SER_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_serializer;

   localparam int DATA_W    = 4;
   localparam int BIT_TICKS = 4;
`ifdef SER_PARITY_EN
   localparam int NBITS     = DATA_W + 3;
   localparam int LIT_FRAME = 28;
`else
   localparam int NBITS     = DATA_W + 2;
   localparam int LIT_FRAME = 24;
`endif
   localparam int FRAME_LEN = NBITS * BIT_TICKS;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [3:0] fifo_data = 4'd0;
   logic       fifo_pop, ser_out, busy, frame_done;

   logic       fe1 = 1'b1;
   logic [3:0] fd1 = 4'd15;
   logic       pop1, ser1, busy1, done1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fifo_serializer #(.DATA_W(DATA_W), .BIT_TICKS(BIT_TICKS)) u_dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_pop(fifo_pop), .ser_out(ser_out), .busy(busy), .frame_done(frame_done)
   );

   fifo_serializer #(.DATA_W(DATA_W), .BIT_TICKS(1)) u_dut1 (
      .clk(clk), .reset(reset), .fifo_empty(fe1), .fifo_data(fd1),
      .fifo_pop(pop1), .ser_out(ser1), .busy(busy1), .frame_done(done1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Upstream FIFO: standard (non fall-through) read, data valid after the pop edge
   logic [3:0] fq[$];
   logic [3:0] push_req[$];
   always @(posedge clk) begin
      if (fifo_pop && fq.size() > 0) fifo_data <= fq.pop_front();
      while (push_req.size() > 0) fq.push_back(push_req.pop_front());
      fifo_empty <= (fq.size() == 0);
   end

   task automatic push(input logic [3:0] v);
      push_req.push_back(v);
   endtask

   // Frame-level model: idle -> pop -> load -> FRAME_LEN line cycles -> idle
   int   m_mode = 0;
   int   m_pos = 0;
   logic m_bits[NBITS];
   logic e_ser = 1'b1, e_pop = 1'b0, e_busy = 1'b0, e_done = 1'b0;
   bit   m_valid = 1'b0;
   always @(posedge clk) begin
      e_done = 1'b0;
      if (reset) begin
         m_mode = 0;
         m_pos  = 0;
      end else begin
         case (m_mode)
            0: if (!fifo_empty) m_mode = 1;
            1: m_mode = 2;
            2: begin
               m_bits[0] = 1'b0;
               for (int i = 0; i < DATA_W; i++) m_bits[1+i] = fifo_data[i];
`ifdef SER_PARITY_EN
               m_bits[DATA_W+1] = ^fifo_data;
`endif
               m_bits[NBITS-1] = 1'b1;
               m_mode = 3;
               m_pos  = 0;
            end
            default: begin
               m_pos++;
               if (m_pos == FRAME_LEN) begin
                  m_mode = 0;
                  e_done = 1'b1;
               end
            end
         endcase
      end
      e_pop   = (m_mode == 1);
      e_busy  = (m_mode != 0);
      e_ser   = (m_mode == 3) ? m_bits[m_pos / BIT_TICKS] : 1'b1;
      m_valid = 1'b1;
   end

   // Cycle-by-cycle compare of the main instance against the model
   always @(negedge clk) begin
      if (m_valid) begin
         check("outputs{ser,pop,busy,done}", {28'd0, ser_out, fifo_pop, busy, frame_done},
               {28'd0, e_ser, e_pop, e_busy, e_done});
         if (frame_done === 1'b1) done_cnt++;
      end
   end

   // Wait for a frame start, sample mid-bit, then time frame_done from the start
   task automatic capture_frame(input string name, input logic [7:0] exp_bits);
      int         n;
      int         t0;
      logic [7:0] got;
      n = 0;
      while (ser_out !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, " start_seen"}, n < 200, 1);
      if (n >= 200) return;
      t0  = cyc;
      got = 8'd0;
      for (int k = 0; k < NBITS; k++) begin
         repeat ((k == 0) ? 2 : BIT_TICKS) @(negedge clk);
         got[k] = ser_out;
      end
      check({name, " bits"}, got, exp_bits);
      n = 0;
      while (frame_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, " done_latency"}, cyc - t0, LIT_FRAME);
   endtask

   initial begin
      int         bad;
      int         n;
      int         r;
      int         t0;
      int         d0;
      logic [7:0] got;

      repeat (3) @(negedge clk);
      check("reset ser_out", ser_out, 1);
      check("reset fifo_pop", fifo_pop, 0);
      check("reset busy", busy, 0);
      check("reset frame_done", frame_done, 0);
      reset = 1'b0;

      // Empty FIFO: nothing may happen
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (fifo_pop !== 1'b0 || busy !== 1'b0 || ser_out !== 1'b1) bad++;
      end
      check("idle_empty_quiet", bad, 0);

      // Single word 10
      push(4'd10);
`ifdef SER_PARITY_EN
      capture_frame("frame_10", 8'b0101_0100);
      push(4'd7);
      capture_frame("frame_7", 8'b0110_1110);
`else
      capture_frame("frame_10", 8'b0011_0100);
`endif
      repeat (5) @(negedge clk);

      // Four back-to-back words
      d0 = done_cnt;
      push(4'd10); push(4'd9); push(4'd2); push(4'd3);
      n = 0;
      while (ser_out !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      t0 = cyc;
      n = 0;
      while (frame_done !== 1'b1 || done_cnt - d0 < 3) begin
         if (n >= 400) break;
         @(negedge clk);
         n++;
      end
      check("b2b span", cyc - t0, 4 * LIT_FRAME + 9);
      repeat (3) @(negedge clk);
      check("b2b done_pulses", done_cnt - d0, 4);
      check("b2b fifo_empty", fifo_empty, 1);
      check("b2b busy", busy, 0);

      // Reset mid-DATA of 9, then 3 must go out intact
      push(4'd9);
      n = 0;
      while (ser_out !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (BIT_TICKS + 3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset ser_out", ser_out, 1);
      check("midreset busy", busy, 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midreset no_replay", busy, 0);
      push(4'd3);
`ifdef SER_PARITY_EN
      capture_frame("frame_3", 8'b0100_0110);
`else
      capture_frame("frame_3", 8'b0010_0110);
`endif

      // BIT_TICKS=1 instance, word 15
      fe1 = 1'b0;
      n = 0;
      while (pop1 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      fe1 = 1'b1;
      n = 0;
      while (ser1 !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      got = 8'd0;
      got[0] = ser1;
      for (int k = 1; k < NBITS; k++) begin
         @(negedge clk);
         got[k] = ser1;
      end
`ifdef SER_PARITY_EN
      check("bt1 bits", got, 8'b0101_1110);
`else
      check("bt1 bits", got, 8'b0011_1110);
`endif
      @(negedge clk);
      check("bt1 frame_done", done1, 1);
      check("bt1 no_repop", pop1, 0);

      // Randomised traffic with occasional resets
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 99);
         if (r < 8) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end else if (r < 60) begin
            push(4'($urandom_range(0, 15)));
         end else if (r < 75) begin
            push(4'($urandom_range(0, 15)));
            push(4'($urandom_range(0, 15)));
            push(4'($urandom_range(0, 15)));
         end
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      n = 0;
      while ((fifo_empty !== 1'b1 || busy !== 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("random drain", n < 3000, 1);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 Parameter: DATA_W, 4, width of each FIFO word, and also the number of data bits per serial frame.
REQ-002 Parameter: BIT_TICKS, 4, clock cycles per serial bit; legal range 1..255.
REQ-003 Port: clk  input  1  the single clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: fifo_empty  input  1  empty flag from the upstream fifo.
REQ-006 Port: fifo_data  input  DATA_W  data_out of the upstream fifo.
REQ-007 Port: fifo_pop  output  1  pop strobe to the upstream fifo.
REQ-008 Port: ser_out  output  1  serial line; idles high.
REQ-009 Port: busy  output  1  high whenever the state is not IDLE.
REQ-010 Port: frame_done  output  1  one-cycle pulse after each stop bit completes.

Function
REQ-011 The block SHALL be a registered FSM with states IDLE, POP, LOAD, START, DATA, PARITY, STOP.
REQ-012 The FSM SHALL move from IDLE to POP when fifo_empty=0; otherwise it SHALL stay in IDLE with ser_out=1.
REQ-013 In POP, fifo_pop SHALL be 1 for exactly one cycle; fifo_pop SHALL be 0 in every other state.
REQ-014 The upstream contract SHALL be that fifo_data is valid the cycle after the pop edge.
REQ-015 In LOAD, the block SHALL capture fifo_data into the shift register; LOAD lasts one cycle.
REQ-016 START SHALL drive ser_out=0 for BIT_TICKS cycles.
REQ-017 DATA SHALL drive DATA_W bits LSB first, each for BIT_TICKS cycles, using a bit counter of width clog2(DATA_W).
REQ-018 STOP SHALL drive ser_out=1 for BIT_TICKS cycles.
REQ-019 The tick counter SHALL count 0..BIT_TICKS-1 and wrap to 0 on every bit boundary.
REQ-020 ser_out SHALL be registered; the START low level appears the cycle after LOAD.
REQ-021 frame_done SHALL pulse for one cycle on the final STOP tick, and the FSM SHALL enter IDLE on the same edge.
REQ-022 Back-to-back frames: if fifo_empty=0 in the IDLE cycle after a frame, the next POP follows; there is no extra gap cycle.
REQ-023 fifo_empty and fifo_data SHALL be ignored outside IDLE and LOAD respectively.
REQ-024 Latency from fifo_empty falling (while in IDLE) to the first START cycle SHALL be 3 cycles: IDLE, POP, LOAD.

Reset
REQ-025 While reset=1 at a clk edge, the FSM SHALL enter IDLE with ser_out=1, fifo_pop=0, busy=0, frame_done=0, and counters and shift register at 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, and the popped word SHALL be discarded, not replayed.
REQ-027 Reset SHALL take priority over all other inputs.

Configuration
REQ-028 With SER_PARITY_EN defined, PARITY SHALL follow DATA and drive the even-parity bit (XOR of the data bits) for BIT_TICKS cycles; frame length is (DATA_W+3)*BIT_TICKS.
REQ-029 Without SER_PARITY_EN, PARITY SHALL be unreachable, DATA SHALL go directly to STOP, and frame length is (DATA_W+2)*BIT_TICKS.

Structure
REQ-030 A shared package SHALL hold the state enum, the DATA_W and BIT_TICKS defaults, and the ser_out idle level.
REQ-031 One sub-module, ser_tick_counter, SHALL generate the bit-boundary strobe from BIT_TICKS.
REQ-032 The FSM, shift register and bit counter SHALL live in fifo_serializer.
REQ-033 The top-level bench SHALL instantiate the existing fifo feeding fifo_serializer.

Verification
REQ-034 Push 4'd10, no parity, BIT_TICKS=4 -> one fifo_pop pulse; ser_out 0,0,1,0,1,1 at 4 cycles per bit; frame_done 24 cycles after the first START cycle.
REQ-035 Push 4'd10, 4'd9, 4'd2, 4'd3 back-to-back -> four frames in order with no idle gap beyond the POP/LOAD cycles; four frame_done pulses; fifo_empty=1 at the end.
REQ-036 SER_PARITY_EN: push 4'd7 -> parity bit 1; push 4'd10 -> parity bit 0; frame length 28 cycles.
REQ-037 fifo_empty held at 1 -> fifo_pop never asserts, busy=0, ser_out=1.
REQ-038 Reset pulse during DATA of 4'd9 -> next cycle ser_out=1 and busy=0; the following pushed word 4'd3 transmits correctly.
REQ-039 BIT_TICKS=1, push 4'd15 -> ser_out 0,1,1,1,1,1 on consecutive cycles.
